// File: rtl/bellek_hakem.sv
// bellek_hakem: arbiter that shares one single-ported memory between an
// instruction-fetch port (g_*) and a data port (v_*).
//
// One access is in flight at a time. An access runs BOSTA -> ERISIM -> TAMAM.
// The ERISIM phase lasts BEKLEME+1 cycles. The memory read data is
// combinational from bellek_adres and is captured in the last ERISIM cycle.
// The requester's hazir pulse is raised in TAMAM.
//
// Optional feature: define HAKEM_SIRALI_EN to make ties fair. When both ports
// request at once, the port that was not granted most recently wins. With the
// macro undefined, the data port always wins a tie and there is no history
// register.

module bellek_hakem #(
    parameter int unsigned BEKLEME = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        g_istek,
    input  logic [31:0] g_adres,
    output logic        g_hazir,
    output logic [31:0] g_veri,

    input  logic        v_istek,
    input  logic        v_yaz,
    input  logic [31:0] v_adres,
    input  logic [31:0] v_yaz_veri,
    output logic        v_hazir,
    output logic [31:0] v_veri,

    output logic [31:0] bellek_adres,
    input  logic [31:0] bellek_oku_veri,
    output logic [31:0] bellek_yaz_veri,
    output logic        bellek_yaz,

    output logic        mesgul
);

    // Wait count loaded on every grant (legal range 0..15).
    localparam logic [3:0]  BEKLEME_SAYI = 4'(BEKLEME);
    // Address driven out of reset, before any access has been latched.
    localparam logic [31:0] ADRES_BASLANGIC = 32'h8000_0000;

    typedef enum logic [1:0] {
        BOSTA  = 2'd0,
        ERISIM = 2'd1,
        TAMAM  = 2'd2
    } durum_t;

    durum_t     durum;
    durum_t     sonraki;

    logic [3:0] sayac;        // remaining wait cycles of the current access
    logic       secili_veri;  // 1: data port owns the access, 0: fetch port
    logic       yazma;        // latched write flag (always 0 for fetches)

    logic       istek_var;    // at least one port is requesting
    logic       veri_kazanir; // data port wins arbitration this cycle
    logic       sayac_bitti;  // last ERISIM cycle of the access
    logic       son_vurus;    // ERISIM cycle in which the memory is accessed

    assign istek_var   = g_istek | v_istek;
    assign sayac_bitti = (sayac == 4'd0);
    assign son_vurus   = (durum == ERISIM) && sayac_bitti;

`ifdef HAKEM_SIRALI_EN
    // 1 when the most recent grant went to the data port, so the fetch port
    // has priority on the next tie.
    logic son_veri;

    // Remember which port received the most recent grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            son_veri <= 1'b0;
        end else if ((durum == BOSTA) && istek_var) begin
            son_veri <= veri_kazanir;
        end
    end

    // Arbitration: on a tie, grant the port that was not granted last time.
    always_comb begin
        veri_kazanir = v_istek;
        if (v_istek && g_istek) begin
            veri_kazanir = !son_veri;
        end
    end
`else
    // Arbitration: the data port always wins a tie.
    always_comb begin
        veri_kazanir = v_istek;
    end
`endif

    // State register.
    // NOTE: clocked state uses non-blocking assignments so that every
    // register in the design samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            durum <= BOSTA;
        end else begin
            durum <= sonraki;
        end
    end

    // Next-state logic: BOSTA waits for a request, ERISIM waits for the
    // counter, TAMAM lasts exactly one cycle.
    // NOTE: sonraki gets a default before the case so that no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        sonraki = durum;
        unique case (durum)
            BOSTA:   if (istek_var) sonraki = ERISIM;
            ERISIM:  if (sayac_bitti) sonraki = TAMAM;
            TAMAM:   sonraki = BOSTA;
            default: sonraki = BOSTA;
        endcase
    end

    // Grant latch and wait counter. Requests are sampled only in BOSTA.
    // Address and store data are held between accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            sayac           <= 4'd0;
            secili_veri     <= 1'b0;
            yazma           <= 1'b0;
            bellek_adres    <= ADRES_BASLANGIC;
            bellek_yaz_veri <= 32'd0;
        end else begin
            unique case (durum)
                BOSTA: begin
                    if (istek_var) begin
                        sayac       <= BEKLEME_SAYI;
                        secili_veri <= veri_kazanir;
                        if (veri_kazanir) begin
                            bellek_adres    <= v_adres;
                            bellek_yaz_veri <= v_yaz_veri;
                            yazma           <= v_yaz;
                        end else begin
                            bellek_adres <= g_adres;
                            yazma        <= 1'b0;
                        end
                    end
                end
                ERISIM: begin
                    if (!sayac_bitti) begin
                        sayac <= sayac - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Response registers: capture the memory word on the last ERISIM cycle
    // of a read. A data write leaves v_veri untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            g_veri <= 32'd0;
            v_veri <= 32'd0;
        end else if (son_vurus && !yazma) begin
            if (secili_veri) begin
                v_veri <= bellek_oku_veri;
            end else begin
                g_veri <= bellek_oku_veri;
            end
        end
    end

    // Outputs decoded from state. The strobes are masked by rst so that an
    // access aborted by reset shows no write or hazir pulse, even in the
    // reset cycle itself.
    always_comb begin
        g_hazir    = 1'b0;
        v_hazir    = 1'b0;
        bellek_yaz = 1'b0;
        mesgul     = (durum != BOSTA);
        if (!rst) begin
            if (durum == TAMAM) begin
                g_hazir = !secili_veri;
                v_hazir = secili_veri;
            end
            if (son_vurus && secili_veri && yazma) begin
                bellek_yaz = 1'b1;
            end
        end
    end

endmodule

// File: doc/bellek_hakem.md
BELLEK_HAKEM -- requirements
Module: bellek_hakem

Interface
REQ-001 Parameter BEKLEME, default 1, range 0..15: extra memory wait cycles per access.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 g_istek  input  1  fetch request; g_adres input 32 fetch address.
REQ-005 g_hazir  output  1  fetch done, one-cycle pulse; g_veri output 32 fetched word.
REQ-006 v_istek  input  1  data request; v_yaz input 1 write (1) or read (0).
REQ-007 v_adres  input  32  data address; v_yaz_veri input 32 store data.
REQ-008 v_hazir  output  1  data done, one-cycle pulse; v_veri output 32 loaded word.
REQ-009 bellek_adres  output  32  memory address; bellek_oku_veri input 32 memory read data, combinational from bellek_adres.
REQ-010 bellek_yaz_veri  output  32  memory write data; bellek_yaz output 1 memory write strobe.
REQ-011 mesgul  output  1  high when the FSM is not in BOSTA.

Function
REQ-012 The FSM SHALL have states BOSTA, ERISIM and TAMAM.
REQ-013 BOSTA: if any istek=1, grant one requester, latch its address/write flag/store data, load counter with BEKLEME, go to ERISIM; else stay.
REQ-014 Request inputs SHALL be sampled only in BOSTA; changes after grant SHALL be ignored.
REQ-015 ERISIM: bellek_adres SHALL equal the latched address; counter decrements each cycle; when counter=0, capture bellek_oku_veri into the granted port's response register and go to TAMAM.
REQ-016 bellek_yaz SHALL be 1 only in the ERISIM cycle with counter=0 of a granted data write, for exactly one cycle; fetches never write.
REQ-017 TAMAM: assert the granted port's hazir for exactly one cycle, then go to BOSTA.
REQ-018 Latency from istek sampled in BOSTA to hazir SHALL be BEKLEME+2 cycles; one access is in flight at a time.
REQ-019 g_veri/v_veri SHALL hold their last captured value until the next completed access on that port; a data write SHALL NOT update v_veri.
REQ-020 A requester still asserting istek in the cycle after its hazir SHALL be treated as issuing a new request.
REQ-021 In idle cycles bellek_adres and bellek_yaz_veri SHALL hold their last latched values.

Reset
REQ-022 On rst: state BOSTA, counter 0, g_hazir=v_hazir=0, bellek_yaz=0, mesgul=0, bellek_adres=32'h8000_0000, bellek_yaz_veri=0, g_veri=v_veri=0, round-robin flag 0.
REQ-023 rst in ERISIM or TAMAM SHALL abort the access: no bellek_yaz pulse and no hazir pulse in or after the reset cycle.

Configuration
REQ-024 Macro HAKEM_SIRALI_EN defined: when both request in BOSTA, grant the port not granted most recently (flag reset 0 = data wins first); flag updates on every grant.
REQ-025 HAKEM_SIRALI_EN undefined: when both request, data port always wins; no flag register.

Verification
REQ-026 BEKLEME=1, g_istek=1, g_adres=0x8000_0000, memory word 0x0000_0013 -> g_hazir pulse at cycle 3, g_veri=0x0000_0013, bellek_yaz never 1.
REQ-027 BEKLEME=2, v_istek=1, v_yaz=1, v_adres=0x8000_0100, v_yaz_veri=0xDEAD_BEEF -> single bellek_yaz pulse with that address/data at cycle 3, v_hazir at cycle 4, v_veri unchanged.
REQ-028 Both istek=1 held continuously, macro undefined -> grants D,D,D...; macro defined -> grants D,G,D,G, each hazir BEKLEME+2 cycles apart per access plus one BOSTA cycle.
REQ-029 BEKLEME=0, data read at 0x8000_0004 returning 0x1234_5678 -> v_hazir at cycle 2, v_veri=0x1234_5678.
REQ-030 Data write granted, rst asserted in first ERISIM cycle with BEKLEME=3 -> no bellek_yaz pulse, no v_hazir, bellek_adres=0x8000_0000 next cycle, mesgul=0.
REQ-031 g_adres changed from 0x8000_0000 to 0x8000_0008 one cycle after grant -> bellek_adres stays 0x8000_0000 for the whole access.
